// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Single-clock raster timing generator for VGA/SXGA outputs. One pixel
//   clock drives both the horizontal and vertical counters (the vertical
//   counter advances on the horizontal wrap, with no derived clock). The
//   counters are decoded into registered sync, blank, coordinate and strobe
//   outputs. Sync and blank can be delayed to match pixel-pipeline latency.
//
// Ports
//   clk          pixel clock
//   rst          synchronous active-high reset
//   en           run enable; counters hold while low
//   hsync/vsync  sync to VGA connector, polarity set by H_POL/V_POL,
//                delayed by SYNC_DLY clocks
//   blank_n      ADV7123 blank (high in active area), delayed by SYNC_DLY
//   sync_n       ADV7123 sync-on-green input, tied low
//   disp_enable  active-area flag, undelayed
//   x_pix/y_pix  active-area coordinates, zero outside the active area
//   line_start   one-clock pulse at the first pixel of each active line
//   frame_start  one-clock pulse at pixel (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_DISP   = 1280,
    parameter int H_FRONT  = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BACK   = 248,
    parameter int V_DISP   = 1024,
    parameter int V_FRONT  = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 38,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int SYNC_DLY = 0,
    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic          sync_n,
    output logic          disp_enable,
    output logic [XW-1:0] x_pix,
    output logic [YW-1:0] y_pix,
    output logic          line_start,
    output logic          frame_start
);

    // Asserted / idle levels of the sync outputs.
    localparam logic HS_ON  = (H_POL != 0);
    localparam logic VS_ON  = (V_POL != 0);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_OFF = ~VS_ON;

    generate
        if (H_DISP < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_DISP < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
            $error("vga_timing_gen: every display/porch/sync parameter must be >= 1");
        end
        if (SYNC_DLY < 0 || SYNC_DLY > 15) begin : g_bad_dly
            $error("vga_timing_gen: SYNC_DLY must be in 0..15");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [XW-1:0] r_h_cnt;
    logic [YW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h_cnt == XW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == YW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                // Vertical counter only moves on the horizontal wrap, so
                // vsync can never change in the middle of a line.
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Region decode (line order: display, front porch, sync, back porch)
    // ------------------------------------------------------------------
    logic w_h_act, w_v_act, w_h_syn, w_v_syn, w_de;

    assign w_h_act = (r_h_cnt < XW'(H_DISP));
    assign w_v_act = (r_v_cnt < YW'(V_DISP));
    assign w_h_syn = (r_h_cnt >= XW'(H_DISP + H_FRONT)) &&
                     (r_h_cnt <  XW'(H_DISP + H_FRONT + H_SYNC));
    assign w_v_syn = (r_v_cnt >= YW'(V_DISP + V_FRONT)) &&
                     (r_v_cnt <  YW'(V_DISP + V_FRONT + V_SYNC));
    assign w_de    = w_h_act & w_v_act;

    // ------------------------------------------------------------------
    // Stage 1: registered decode. Runs regardless of en, so the strobes
    // stay high while the counters are parked at their start position.
    // ------------------------------------------------------------------
    logic          r_de;
    logic [XW-1:0] r_x_pix;
    logic [YW-1:0] r_y_pix;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_hs1;
    logic          r_vs1;
    logic          r_bn1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de          <= 1'b0;
            r_x_pix       <= '0;
            r_y_pix       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs1         <= HS_OFF;
            r_vs1         <= VS_OFF;
            r_bn1         <= 1'b0;
        end else begin
            r_de          <= w_de;
            r_x_pix       <= w_de ? r_h_cnt : '0;
            r_y_pix       <= w_de ? r_v_cnt : '0;
            r_line_start  <= (r_h_cnt == '0) & w_v_act;
            r_frame_start <= (r_h_cnt == '0) & (r_v_cnt == '0);
            r_hs1         <= w_h_syn ? HS_ON : HS_OFF;
            r_vs1         <= w_v_syn ? VS_ON : VS_OFF;
            r_bn1         <= w_de;
        end
    end

    assign disp_enable = r_de;
    assign x_pix       = r_x_pix;
    assign y_pix       = r_y_pix;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign sync_n      = 1'b0;

    // ------------------------------------------------------------------
    // Sync/blank delay line. Each word is {hsync, vsync, blank_n}; reset
    // fills every stage with the idle levels so no stale pulse escapes.
    // ------------------------------------------------------------------
    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign hsync   = r_hs1;
            assign vsync   = r_vs1;
            assign blank_n = r_bn1;
        end else begin : g_dly
            logic [2:0] r_sb_pipe [SYNC_DLY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_DLY; i++) begin
                        r_sb_pipe[i] <= {HS_OFF, VS_OFF, 1'b0};
                    end
                end else begin
                    r_sb_pipe[0] <= {r_hs1, r_vs1, r_bn1};
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        r_sb_pipe[i] <= r_sb_pipe[i-1];
                    end
                end
            end

            assign hsync   = r_sb_pipe[SYNC_DLY-1][2];
            assign vsync   = r_sb_pipe[SYNC_DLY-1][1];
            assign blank_n = r_sb_pipe[SYNC_DLY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances share one clock: the default SXGA configuration, and a
//   tiny 8x6 configuration (active-low syncs) with SYNC_DLY=0 and =3.
//   Each clock the bench predicts every output from a raster position
//   (count of enabled clocks since reset, split into line/column with
//   div/mod) and compares. Enable and reset are randomized, with a directed
//   5-clock enable gap and a directed mid-frame reset.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int de, x, y, ls, fs, hs, vs, bn;
    } exp_t;

    // Default configuration
    localparam int D_HT = 1280 + 48 + 112 + 248;
    localparam int D_VT = 1024 + 1 + 3 + 38;
    // Small configuration: H 4/1/2/1, V 3/1/1/1
    localparam int S_HT = 8;
    localparam int S_VT = 6;
    localparam int N_CYC = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, en_d, rst_s, en_s;

    logic        d_hs, d_vs, d_bn, d_sn, d_de, d_ls, d_fs;
    logic [10:0] d_x, d_y;
    logic        a_hs, a_vs, a_bn, a_sn, a_de, a_ls, a_fs;
    logic [2:0]  a_x, a_y;
    logic        b_hs, b_vs, b_bn, b_sn, b_de, b_ls, b_fs;
    logic [2:0]  b_x, b_y;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_d), .en(en_d),
        .hsync(d_hs), .vsync(d_vs), .blank_n(d_bn), .sync_n(d_sn),
        .disp_enable(d_de), .x_pix(d_x), .y_pix(d_y),
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_DISP(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISP(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(0), .V_POL(0), .SYNC_DLY(0)
    ) u_sm0 (
        .clk(clk), .rst(rst_s), .en(en_s),
        .hsync(a_hs), .vsync(a_vs), .blank_n(a_bn), .sync_n(a_sn),
        .disp_enable(a_de), .x_pix(a_x), .y_pix(a_y),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_DISP(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISP(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(0), .V_POL(0), .SYNC_DLY(3)
    ) u_sm3 (
        .clk(clk), .rst(rst_s), .en(en_s),
        .hsync(b_hs), .vsync(b_vs), .blank_n(b_bn), .sync_n(b_sn),
        .disp_enable(b_de), .x_pix(b_x), .y_pix(b_y),
        .line_start(b_ls), .frame_start(b_fs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected stage-1 outputs for raster position (h,v).
    function automatic exp_t decode(int h, int v, int hd, int hf, int hsw,
                                    int vd, int vf, int vsw, int hp, int vp);
        exp_t e;
        int act;
        act  = (h < hd && v < vd) ? 1 : 0;
        e.de = act;
        e.x  = act ? h : 0;
        e.y  = act ? v : 0;
        e.ls = (h == 0 && v < vd) ? 1 : 0;
        e.fs = (h == 0 && v == 0) ? 1 : 0;
        e.hs = (h >= hd + hf && h < hd + hf + hsw) ? hp : 1 - hp;
        e.vs = (v >= vd + vf && v < vd + vf + vsw) ? vp : 1 - vp;
        e.bn = act;
        return e;
    endfunction

    function automatic exp_t reset_val(int hp, int vp);
        exp_t e;
        e.de = 0; e.x = 0; e.y = 0; e.ls = 0; e.fs = 0;
        e.hs = 1 - hp; e.vs = 1 - vp; e.bn = 0;
        return e;
    endfunction

    task automatic check_inst(input string nm, input int cyc, input exp_t e,
                              input logic hs, input logic vs, input logic bn,
                              input logic sn, input logic de,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic ls, input logic fs);
        check_eq($sformatf("%s.hsync c%0d", nm, cyc), {31'd0, hs}, e.hs);
        check_eq($sformatf("%s.vsync c%0d", nm, cyc), {31'd0, vs}, e.vs);
        check_eq($sformatf("%s.blank_n c%0d", nm, cyc), {31'd0, bn}, e.bn);
        check_eq($sformatf("%s.sync_n c%0d", nm, cyc), {31'd0, sn}, 0);
        check_eq($sformatf("%s.disp_enable c%0d", nm, cyc), {31'd0, de}, e.de);
        check_eq($sformatf("%s.x_pix c%0d", nm, cyc), x, e.x);
        check_eq($sformatf("%s.y_pix c%0d", nm, cyc), y, e.y);
        check_eq($sformatf("%s.line_start c%0d", nm, cyc), {31'd0, ls}, e.ls);
        check_eq($sformatf("%s.frame_start c%0d", nm, cyc), {31'd0, fs}, e.fs);
    endtask

    initial begin
        int   pos_d, pos_s, gap_cnt;
        bit   gap_done, mid_done;
        exp_t e_d, e_s, e_s3, r_s;
        exp_t hist[$];

        pos_d = 0; pos_s = 0; gap_cnt = 0;
        gap_done = 0; mid_done = 0;
        r_s = reset_val(0, 0);
        for (int i = 0; i < 4; i++) hist.push_back(r_s);

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            // ---- default instance stimulus ----
            rst_d = (cyc < 3);
            if (gap_cnt > 0) begin
                en_d = 1'b0;
                gap_cnt--;
            end else if (!rst_d && !gap_done && pos_d == D_HT + 2) begin
                en_d     = 1'b0;   // 5-clock hold parked at column 2
                gap_cnt  = 4;
                gap_done = 1;
            end else begin
                en_d = ($urandom_range(0, 49) != 0);
            end
            // ---- small instances stimulus ----
            if (cyc < 3) begin
                rst_s = 1'b1;
            end else if (!mid_done && cyc > 600 && pos_s == 2 * S_HT + 3) begin
                rst_s    = 1'b1;   // reset at line 2, column 3
                mid_done = 1;
            end else begin
                rst_s = ($urandom_range(0, 299) == 0);
            end
            en_s = ($urandom_range(0, 3) != 0);

            @(posedge clk);
            #1;

            // ---- predictions ----
            if (rst_d) begin
                e_d   = reset_val(1, 1);
                pos_d = 0;
            end else begin
                e_d = decode(pos_d % D_HT, pos_d / D_HT, 1280, 48, 112, 1024, 1, 3, 1, 1);
                if (en_d) pos_d = (pos_d + 1) % (D_HT * D_VT);
            end

            if (rst_s) begin
                e_s   = r_s;
                pos_s = 0;
                hist.delete();
                for (int i = 0; i < 4; i++) hist.push_back(r_s);
            end else begin
                e_s = decode(pos_s % S_HT, pos_s / S_HT, 4, 1, 2, 3, 1, 1, 0, 0);
                if (en_s) pos_s = (pos_s + 1) % (S_HT * S_VT);
                hist.push_front(e_s);
                void'(hist.pop_back());
            end
            // Delayed instance: sync/blank from three clocks earlier,
            // everything else as the undelayed one.
            e_s3    = e_s;
            e_s3.hs = hist[3].hs;
            e_s3.vs = hist[3].vs;
            e_s3.bn = hist[3].bn;

            check_inst("def", cyc, e_d, d_hs, d_vs, d_bn, d_sn, d_de,
                       {21'd0, d_x}, {21'd0, d_y}, d_ls, d_fs);
            check_inst("sm0", cyc, e_s, a_hs, a_vs, a_bn, a_sn, a_de,
                       {29'd0, a_x}, {29'd0, a_y}, a_ls, a_fs);
            check_inst("sm3", cyc, e_s3, b_hs, b_vs, b_bn, b_sn, b_de,
                       {29'd0, b_x}, {29'd0, b_y}, b_ls, b_fs);
        end

        if (!gap_done) check_eq("enable_gap_reached", 0, 1);
        if (!mid_done) check_eq("midframe_reset_reached", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
